// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine controller: state codes,
// motor drive levels and load-mode selections.
package wm_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHARGE = 3'd1;
  localparam logic [2:0] ST_WASH   = 3'd2;
  localparam logic [2:0] ST_RINSE  = 3'd3;
  localparam logic [2:0] ST_SPIN   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CHARGE = ST_CHARGE,
    S_WASH   = ST_WASH,
    S_RINSE  = ST_RINSE,
    S_SPIN   = ST_SPIN,
    S_DONE   = ST_DONE,
    S_ERR    = ST_ERR
  } state_t;

  localparam logic [1:0] MOTOR_OFF  = 2'b00;
  localparam logic [1:0] MOTOR_SLOW = 2'b01;
  localparam logic [1:0] MOTOR_SPIN = 2'b10;

  localparam logic [1:0] MODE_DRY = 2'b00;
  localparam logic [1:0] MODE_S   = 2'b01;
  localparam logic [1:0] MODE_M   = 2'b10;
  localparam logic [1:0] MODE_L   = 2'b11;

endpackage

// File: rtl/wash_cycle_ctrl_if.sv
// User-input/billing side and actuator/display side of the wash controller.
// master drives the run request; slave is the controller itself.
interface wash_cycle_ctrl_if;
  logic        on;
  logic        start;
  logic        pause;
  logic [1:0]  mode;
  logic [11:0] bal;
  logic [11:0] set0;
  logic [11:0] set1;
  logic [11:0] set2;
  logic [11:0] set3;
  logic [11:0] bal_new;
  logic        bal_we;
  logic [2:0]  phase;
  logic [11:0] secs_left;
  logic        fill;
  logic [1:0]  motor;
  logic        drain;
  logic        done;
  logic        err_funds;

  modport master (
    output on, start, pause, mode, bal, set0, set1, set2, set3,
    input  bal_new, bal_we, phase, secs_left, fill, motor, drain, done, err_funds
  );

  modport slave (
    input  on, start, pause, mode, bal, set0, set1, set2, set3,
    output bal_new, bal_we, phase, secs_left, fill, motor, drain, done, err_funds
  );
endinterface

// File: rtl/sec_tick.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Holding en low freezes the count, so a partial second is never lost.
module sec_tick #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Single-run washing-machine sequencer: latch mode/price, charge the balance,
// then time wash/rinse/spin phases on a 1 s tick and drive the actuators.
module wash_cycle_ctrl
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter logic [11:0] WASH_S   = 12'd20,
  parameter logic [11:0] WASH_M   = 12'd30,
  parameter logic [11:0] WASH_L   = 12'd40,
  parameter logic [11:0] RINSE_T  = 12'd10,
  parameter logic [11:0] SPIN_T   = 12'd8
) (
  input logic             clk,
  input logic             rst,
  wash_cycle_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic [11:0] secs_q, secs_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] price_q, price_d;
  logic [11:0] set_sel;
  logic [11:0] bal_new;
  logic        bal_we;
  logic        run, tick, clr, en;

  function automatic logic [11:0] wash_dur(input logic [1:0] m);
    case (m)
      MODE_S:  return WASH_S;
      MODE_M:  return WASH_M;
      MODE_L:  return WASH_L;
      default: return 12'd0;
    endcase
  endfunction

  assign run = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
  assign en  = run && bus.on && !bus.pause;
  // Any state change restarts the second, so each phase begins on a fresh count.
  assign clr = !run || (state_d != state_q);

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    case (bus.mode)
      2'b00:   set_sel = bus.set0;
      2'b01:   set_sel = bus.set1;
      2'b10:   set_sel = bus.set2;
      default: set_sel = bus.set3;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    mode_d  = mode_q;
    price_d = price_q;
    bal_we  = 1'b0;
    bal_new = '0;
    if (!bus.on) begin
      state_d = S_IDLE;
      secs_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          mode_d  = bus.mode;
          price_d = set_sel;
          state_d = S_CHARGE;
        end
        S_CHARGE: if (bus.bal >= price_q) begin
          bal_we  = 1'b1;
          bal_new = bus.bal - price_q;
          if (mode_q == MODE_DRY) begin
            state_d = S_SPIN;
            secs_d  = SPIN_T;
          end else begin
            state_d = S_WASH;
            secs_d  = wash_dur(mode_q);
          end
        end else begin
          state_d = S_ERR;
        end
        S_WASH, S_RINSE, S_SPIN: begin
          // A zero-length phase falls through on its entry cycle.
          if ((secs_q == 12'd0) || (tick && (secs_q == 12'd1))) begin
            case (state_q)
              S_WASH:  begin state_d = S_RINSE; secs_d = RINSE_T; end
              S_RINSE: begin state_d = S_SPIN;  secs_d = SPIN_T;  end
              default: begin state_d = S_DONE;  secs_d = '0;      end
            endcase
          end else if (tick) begin
            secs_d = secs_q - 12'd1;
          end
        end
        S_DONE, S_ERR: if (bus.start) begin
          state_d = S_IDLE;
          secs_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
          secs_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      secs_q  <= '0;
      mode_q  <= '0;
      price_q <= '0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      mode_q  <= mode_d;
      price_q <= price_d;
    end
  end

  always_comb begin
    bus.fill  = 1'b0;
    bus.drain = 1'b0;
    bus.motor = MOTOR_OFF;
    if (!bus.pause) begin
      case (state_q)
        S_WASH:  begin bus.fill = 1'b1; bus.motor = MOTOR_SLOW; end
        S_RINSE: begin bus.fill = 1'b1; bus.drain = 1'b1; bus.motor = MOTOR_SLOW; end
        S_SPIN:  begin bus.drain = 1'b1; bus.motor = MOTOR_SPIN; end
        default: ;
      endcase
    end
  end

  assign bus.phase     = state_q;
  assign bus.secs_left = secs_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.err_funds = (state_q == S_ERR);
  assign bus.bal_we    = bal_we;
  assign bus.bal_new   = bal_new;

endmodule
